// File: rtl/pulse_cfg_sched_if.sv
// Requester and pulse-bank signal bundle for pulse_cfg_sched.
// master = requesters/bank side, slave = the sequencer.
interface pulse_cfg_sched_if;
  logic        host_req;
  logic [3:0]  host_ch;
  logic [31:0] host_delay;
  logic [31:0] host_width;
  logic        host_ack;
  logic        host_err;
  logic        seq_req;
  logic [3:0]  seq_ch;
  logic [31:0] seq_delay;
  logic [31:0] seq_width;
  logic        seq_ack;
  logic        seq_err;
  logic [31:0] PulseSelect_reg;
  logic [31:0] PulseDelay_reg;
  logic [31:0] PulseWidth_reg;
  logic        busy;
  logic [13:0] cfg_valid;

  modport master (
    output host_req, host_ch, host_delay, host_width,
    output seq_req, seq_ch, seq_delay, seq_width,
    input  host_ack, host_err, seq_ack, seq_err,
    input  PulseSelect_reg, PulseDelay_reg, PulseWidth_reg, busy, cfg_valid
  );

  modport slave (
    input  host_req, host_ch, host_delay, host_width,
    input  seq_req, seq_ch, seq_delay, seq_width,
    output host_ack, host_err, seq_ack, seq_err,
    output PulseSelect_reg, PulseDelay_reg, PulseWidth_reg, busy, cfg_valid
  );
endinterface

// File: rtl/pulse_cfg_sched.sv
// Round-robin configuration sequencer for the 14-channel pulse bank: one
// channel latches new delay/width per transaction via setup/latch/release.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; arbitrates and captures on grant
// SETUP   | delay/width driven to the bank, select still 0
// LATCH   | select = {load, ch} for HOLD_CYCLES cycles
// RELEASE | select back to 0, delay/width held, channel marked valid
// DONE    | ack (and err if rejected) to the granted requester
module pulse_cfg_sched #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  pulse_cfg_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LATCH,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] MAX_CH    = 4'd13;

  state_t      state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  ch_q, ch_d;
  logic        gnt_seq_q, gnt_seq_d;
  logic        last_seq_q, last_seq_d;
  logic [31:0] delay_q, delay_d;
  logic [31:0] width_q, width_d;
  logic [4:0]  sel_q, sel_d;
  logic [13:0] cfg_valid_q, cfg_valid_d;
  logic        busy_q, busy_d;
  logic        host_ack_q, host_ack_d;
  logic        host_err_q, host_err_d;
  logic        seq_ack_q, seq_ack_d;
  logic        seq_err_q, seq_err_d;

  logic        pick_seq;
  logic [3:0]  req_ch;
  logic [31:0] req_delay;
  logic [31:0] req_width;

  // On a tie the requester not served last time wins.
  always_comb begin
    pick_seq  = bus.seq_req && (!bus.host_req || !last_seq_q);
    req_ch    = pick_seq ? bus.seq_ch    : bus.host_ch;
    req_delay = pick_seq ? bus.seq_delay : bus.host_delay;
    req_width = pick_seq ? bus.seq_width : bus.host_width;
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    ch_d        = ch_q;
    gnt_seq_d   = gnt_seq_q;
    last_seq_d  = last_seq_q;
    delay_d     = delay_q;
    width_d     = width_q;
    sel_d       = 5'd0;
    cfg_valid_d = cfg_valid_q;
    host_ack_d  = 1'b0;
    host_err_d  = 1'b0;
    seq_ack_d   = 1'b0;
    seq_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.host_req || bus.seq_req) begin
          ch_d       = req_ch;
          gnt_seq_d  = pick_seq;
          last_seq_d = pick_seq;
          if (req_ch > MAX_CH) begin
            // Rejected: straight to DONE, bank registers untouched.
            state_d    = S_DONE;
            host_ack_d = !pick_seq;
            host_err_d = !pick_seq;
            seq_ack_d  = pick_seq;
            seq_err_d  = pick_seq;
          end else begin
            state_d = S_SETUP;
            delay_d = req_delay;
            width_d = req_width;
          end
        end
      end
      S_SETUP: begin
        state_d = S_LATCH;
        hold_d  = HOLD_INIT;
        sel_d   = {1'b1, ch_q};
      end
      S_LATCH: begin
        if (hold_q == 4'd0) begin
          state_d           = S_RELEASE;
          cfg_valid_d[ch_q] = 1'b1;
        end else begin
          hold_d = hold_q - 4'd1;
          sel_d  = {1'b1, ch_q};
        end
      end
      S_RELEASE: begin
        state_d    = S_DONE;
        host_ack_d = !gnt_seq_q;
        seq_ack_d  = gnt_seq_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hold_q      <= 4'd0;
      ch_q        <= 4'd0;
      gnt_seq_q   <= 1'b0;
      last_seq_q  <= 1'b1;
      delay_q     <= 32'd0;
      width_q     <= 32'd0;
      sel_q       <= 5'd0;
      cfg_valid_q <= 14'd0;
      busy_q      <= 1'b0;
      host_ack_q  <= 1'b0;
      host_err_q  <= 1'b0;
      seq_ack_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      ch_q        <= ch_d;
      gnt_seq_q   <= gnt_seq_d;
      last_seq_q  <= last_seq_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      sel_q       <= sel_d;
      cfg_valid_q <= cfg_valid_d;
      busy_q      <= busy_d;
      host_ack_q  <= host_ack_d;
      host_err_q  <= host_err_d;
      seq_ack_q   <= seq_ack_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign bus.PulseSelect_reg = {27'd0, sel_q};
  assign bus.PulseDelay_reg  = delay_q;
  assign bus.PulseWidth_reg  = width_q;
  assign bus.busy            = busy_q;
  assign bus.cfg_valid       = cfg_valid_q;
  assign bus.host_ack        = host_ack_q;
  assign bus.host_err        = host_err_q;
  assign bus.seq_ack         = seq_ack_q;
  assign bus.seq_err         = seq_err_q;

endmodule
